fsm_seq_detector: RTL and testbench
===================================

# fsm_seq_detector

Parametrised serial-pattern detector FSM, the successor to the fixed-function state machine in the `tt_um_fsm` tile. It accepts a runtime-loadable PAT_W-bit pattern and a qualified serial bit stream, and detects the pattern in overlapping or non-overlapping mode. It reports matches as a registered pulse, a match counter and a sticky flag. The block instantiates inside the tile wrapper, fed from `ui_in` and driving `uo_out`.

## Interface
- PAT_W, 8: pattern length in bits, ≥2.
- CNT_W, 8: match counter width, ≥1.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  detector enable; 0 forces IDLE.
- load  in  1  capture `pat_in` into the pattern register.
- pat_in  in  PAT_W  pattern; MSB is the first bit expected on the stream.
- mode_ovl  in  1  1 = overlapping detection, 0 = non-overlapping.
- bit_in  in  1  serial data bit.
- bit_vld  in  1  `bit_in` qualifier; one bit accepted per cycle with `bit_vld`=1.
- clr  in  1  synchronous clear of `match_cnt` and `sticky`.
- match  out  1  one-cycle pulse per detected match.
- match_cnt  out  CNT_W  number of matches since reset or `clr`.
- sticky  out  1  set on first match; held until `clr` or `rst`.
- state  out  2  FSM state: IDLE=00, ARM=01, RUN=10.

## Operation
- Registers: pattern `pat` (PAT_W), shift window `sh` (PAT_W), fill counter `fill` (0..PAT_W), state.
- On an accepted bit, `sh <= {sh[PAT_W-2:0], bit_in}` and `fill` increments, saturating at PAT_W.
- IDLE: `en`=0. `bit_vld` is ignored; `sh` and `fill` clear. `pat`, `match_cnt` and `sticky` are retained. Transitions to ARM when `en`=1.
- ARM: window filling, `fill` < PAT_W. Transitions to RUN on the edge where `fill` reaches PAT_W. That same bit is compared.
- RUN: every accepted bit is compared. A match occurs when the post-shift window equals `pat`.
- On a match with `mode_ovl`=1: stay in RUN.
- On a match with `mode_ovl`=0: `sh` and `fill` clear and the FSM goes to ARM. The next match needs PAT_W fresh bits.
- `load`=1 in ARM or RUN: `pat <= pat_in`, `sh` and `fill` clear, FSM goes to ARM.
- `load`=1 in IDLE: `pat` is updated; state is unchanged.
- `load` has priority over `bit_vld` in the same cycle. The bit is dropped and no compare is done.
- `en` falling in any state: IDLE on the next edge. This has priority over `load` for state, but `pat` still updates.
- Each match increments `match_cnt` (width rule under Configuration) and sets `sticky`.
- `clr` in the same cycle as a match: `clr` wins, so `match_cnt`=0 and `sticky`=0. The `match` pulse is still issued.
- `mode_ovl` is sampled on each match edge; changing it mid-stream is legal.

## Timing
- Reset values: `match`=0, `match_cnt`=0, `sticky`=0, `state`=00. `pat`, `sh` and `fill` are 0.
- Match latency is 1 cycle. `match` is high during the cycle after the edge that accepted the completing bit.
- `match_cnt` and `sticky` update on that same edge.
- Maximum throughput is one bit per cycle. Back-to-back matches are possible in overlap mode when the pattern is periodic, e.g. all-ones.
- `rst` asserted mid-stream clears all state asynchronously. Operation restarts in IDLE, and `pat` must be reloaded.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `FSM_SEQ_SAT_EN` defined: `match_cnt` saturates at 2^CNT_W−1 and further matches leave it unchanged.
- `FSM_SEQ_SAT_EN` undefined: `match_cnt` wraps modulo 2^CNT_W.
- In both builds, `match` and `sticky` behave identically.

## Test plan
All scenarios use PAT_W=4 and `pat`=1011 unless stated otherwise.
- Reset, then `en`=0 with a stream driven → `state`=00 and all outputs stay 0.
- `load` 1011 with `mode_ovl`=1, stream 1,0,1,1,0,1,1 → `match` pulses after the 4th and 7th bits, `match_cnt`=2, `sticky`=1.
- Same stream with `mode_ovl`=0 → a single match after the 4th bit, `match_cnt`=1, `state`=01 at the end.
- Stream 1,0,1 then `load` of 1011 together with `bit_vld`=1, `bit_in`=1, then stream 1,0,1,1 → no match before the final bit, then 1 match. This checks that `load` clears the window and drops the colliding bit.
- `clr` asserted in the match cycle → `match`=1 that cycle, then `match_cnt`=0 and `sticky`=0.
- CNT_W=2 with 5 overlap matches: with `FSM_SEQ_SAT_EN`, `match_cnt`=3; without it, `match_cnt`=1. A mid-stream `rst` then gives `match_cnt`=0 and `state`=00 immediately.

Source files
------------

// File: rtl/fsm_seq_detector.sv
// ----------------------------------------------------------------------------
// fsm_seq_detector
//
// Serial pattern detector with a runtime-loadable PAT_W-bit pattern. A
// qualified bit stream is shifted into a window, and the window is compared
// against the pattern once PAT_W bits have been collected. Overlapping and
// non-overlapping detection are both supported. A match produces a registered
// one-cycle pulse, increments a counter and sets a sticky flag.
//
// Build option:
//   FSM_SEQ_SAT_EN  defined   -> match_cnt saturates at all-ones
//                   undefined -> match_cnt wraps modulo 2^CNT_W
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   en         in   1      detector enable; 0 forces IDLE
//   load       in   1      capture pat_in into the pattern register
//   pat_in     in   PAT_W  pattern, MSB is the first bit expected
//   mode_ovl   in   1      1 = overlapping, 0 = non-overlapping detection
//   bit_in     in   1      serial data bit
//   bit_vld    in   1      bit_in qualifier
//   clr        in   1      synchronous clear of match_cnt and sticky
//   match      out  1      one-cycle pulse per detected match
//   match_cnt  out  CNT_W  matches since reset or clr
//   sticky     out  1      set on first match, held until clr or rst
//   state      out  2      IDLE=00, ARM=01, RUN=10
// ----------------------------------------------------------------------------
module fsm_seq_detector #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             mode_ovl,
    input  logic             bit_in,
    input  logic             bit_vld,
    input  logic             clr,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             sticky,
    output logic [1:0]       state
);

    localparam int unsigned FillW = $clog2(PAT_W + 1);
    localparam logic [FillW-1:0] FillFull = FillW'(PAT_W);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StArm  = 2'b01,
        StRun  = 2'b10
    } state_e;

    state_e             r_state;
    logic [PAT_W-1:0]   r_pat;
    logic [PAT_W-1:0]   r_sh;
    logic [FillW-1:0]   r_fill;
    logic               r_match;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sticky;

    logic [PAT_W-1:0]   w_sh_nxt;
    logic [FillW-1:0]   w_fill_nxt;
    logic               w_full_nxt;
    logic               w_hit;
    logic               w_take_hit;
    logic [CNT_W-1:0]   w_cnt_inc;

    always_comb begin
        w_sh_nxt   = {r_sh[PAT_W-2:0], bit_in};
        w_fill_nxt = (r_fill == FillFull) ? r_fill : r_fill + FillW'(1);
        w_full_nxt = (w_fill_nxt == FillFull);
        // The bit that completes the window is compared on the same edge.
        w_hit      = w_full_nxt && (w_sh_nxt == r_pat);
        // A compare only happens on an accepted bit while armed or running;
        // load drops the bit and en=0 overrides everything.
        w_take_hit = en && !load && bit_vld && w_hit &&
                     ((r_state == StArm) || (r_state == StRun));
`ifdef FSM_SEQ_SAT_EN
        w_cnt_inc  = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
`else
        w_cnt_inc  = r_cnt + CNT_W'(1);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_pat    <= '0;
            r_sh     <= '0;
            r_fill   <= '0;
            r_match  <= 1'b0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
        end else begin
            r_match <= 1'b0;

            // The pattern register follows load in every state, even when en
            // is dropping in the same cycle.
            if (load) begin
                r_pat <= pat_in;
            end

            // clr beats a coincident match for the counter and sticky flag.
            if (clr) begin
                r_cnt    <= '0;
                r_sticky <= 1'b0;
            end else if (w_take_hit) begin
                r_cnt    <= w_cnt_inc;
                r_sticky <= 1'b1;
            end

            if (!en) begin
                r_state <= StIdle;
                r_sh    <= '0;
                r_fill  <= '0;
            end else begin
                case (r_state)
                    StIdle: begin
                        r_state <= StArm;
                        r_sh    <= '0;
                        r_fill  <= '0;
                    end
                    StArm, StRun: begin
                        if (load) begin
                            r_state <= StArm;
                            r_sh    <= '0;
                            r_fill  <= '0;
                        end else if (bit_vld) begin
                            if (w_hit) begin
                                r_match <= 1'b1;
                                if (mode_ovl) begin
                                    r_state <= StRun;
                                    r_sh    <= w_sh_nxt;
                                    r_fill  <= w_fill_nxt;
                                end else begin
                                    // Non-overlapping: next match needs a fresh window.
                                    r_state <= StArm;
                                    r_sh    <= '0;
                                    r_fill  <= '0;
                                end
                            end else begin
                                r_state <= w_full_nxt ? StRun : StArm;
                                r_sh    <= w_sh_nxt;
                                r_fill  <= w_fill_nxt;
                            end
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                        r_sh    <= '0;
                        r_fill  <= '0;
                    end
                endcase
            end
        end
    end

    assign match     = r_match;
    assign match_cnt = r_cnt;
    assign sticky    = r_sticky;
    assign state     = r_state;

endmodule

// File: tb/tb_fsm_seq_detector.sv
// ----------------------------------------------------------------------------
// tb_fsm_seq_detector
//
// Self-checking bench for fsm_seq_detector with PAT_W=4, CNT_W=2. A table of
// input/expected-output records is applied one per clock; expected values are
// pushed to a scoreboard queue when inputs are driven and popped after the
// edge. Hand-written sequences cover asynchronous reset mid-stream and the
// all-zero pattern left behind by reset.
// ----------------------------------------------------------------------------
module tb_fsm_seq_detector;

    localparam int unsigned PAT_W = 4;
    localparam int unsigned CNT_W = 2;

`ifdef FSM_SEQ_SAT_EN
    localparam logic [1:0] EXP_CNT4 = 2'd3;
    localparam logic [1:0] EXP_CNT5 = 2'd3;
`else
    localparam logic [1:0] EXP_CNT4 = 2'd0;
    localparam logic [1:0] EXP_CNT5 = 2'd1;
`endif

    typedef struct {
        logic       rst;
        logic       en;
        logic       load;
        logic [3:0] pat;
        logic       ovl;
        logic       bin;
        logic       bvld;
        logic       clr;
        logic       e_match;
        logic [1:0] e_cnt;
        logic       e_sticky;
        logic [1:0] e_state;
    } vec_t;

    typedef struct {
        logic       m;
        logic [1:0] c;
        logic       s;
        logic [1:0] st;
        int         id;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             en;
    logic             load;
    logic [PAT_W-1:0] pat_in;
    logic             mode_ovl;
    logic             bit_in;
    logic             bit_vld;
    logic             clr;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             sticky;
    logic [1:0]       state;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    vec_t vecs[45];

    fsm_seq_detector #(
        .PAT_W(PAT_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load      (load),
        .pat_in    (pat_in),
        .mode_ovl  (mode_ovl),
        .bit_in    (bit_in),
        .bit_vld   (bit_vld),
        .clr       (clr),
        .match     (match),
        .match_cnt (match_cnt),
        .sticky    (sticky),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic e, input logic l,
                                input logic [3:0] p, input logic o, input logic b,
                                input logic bv, input logic c, input logic em,
                                input logic [1:0] ec, input logic es,
                                input logic [1:0] est);
        vec_t v;
        v.rst = r; v.en = e; v.load = l; v.pat = p; v.ovl = o; v.bin = b;
        v.bvld = bv; v.clr = c; v.e_match = em; v.e_cnt = ec; v.e_sticky = es;
        v.e_state = est;
        return v;
    endfunction

    task automatic check_bit(input string name, input int id, input logic act,
                             input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %b expected %b", name, id, act, exp);
        end
    endtask

    task automatic check_two(input string name, input int id, input logic [1:0] act,
                             input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %b expected %b", name, id, act, exp);
        end
    endtask

    task automatic compare_head();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        check_bit("match", e.id, match, e.m);
        check_two("match_cnt", e.id, match_cnt, e.c);
        check_bit("sticky", e.id, sticky, e.s);
        check_two("state", e.id, state, e.st);
    endtask

    // Drive one cycle of inputs, queue its expectation, check after the edge.
    task automatic step(input vec_t v, input int id);
        exp_t e;
        rst = v.rst; en = v.en; load = v.load; pat_in = v.pat; mode_ovl = v.ovl;
        bit_in = v.bin; bit_vld = v.bvld; clr = v.clr;
        e.m = v.e_match; e.c = v.e_cnt; e.s = v.e_sticky; e.st = v.e_state; e.id = id;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_head();
    endtask

    initial begin
        // Reset, then en=0 with a stream driven.
        vecs[0]  = mk(1, 0, 0, 4'b0000, 0, 0, 0, 0,  0, 2'd0, 0, 2'b00);
        vecs[1]  = mk(0, 0, 0, 4'b0000, 0, 1, 1, 0,  0, 2'd0, 0, 2'b00);
        vecs[2]  = mk(0, 0, 0, 4'b0000, 0, 1, 1, 0,  0, 2'd0, 0, 2'b00);
        vecs[3]  = mk(0, 0, 0, 4'b0000, 0, 0, 1, 0,  0, 2'd0, 0, 2'b00);
        // Load in IDLE keeps IDLE, then enable -> ARM.
        vecs[4]  = mk(0, 0, 1, 4'b1011, 1, 0, 0, 0,  0, 2'd0, 0, 2'b00);
        vecs[5]  = mk(0, 1, 0, 4'b0000, 1, 0, 0, 0,  0, 2'd0, 0, 2'b01);
        // Overlap stream 1,0,1,1,0,1,1 -> matches after 4th and 7th bits.
        vecs[6]  = mk(0, 1, 0, 4'b0000, 1, 1, 1, 0,  0, 2'd0, 0, 2'b01);
        vecs[7]  = mk(0, 1, 0, 4'b0000, 1, 0, 1, 0,  0, 2'd0, 0, 2'b01);
        vecs[8]  = mk(0, 1, 0, 4'b0000, 1, 1, 1, 0,  0, 2'd0, 0, 2'b01);
        vecs[9]  = mk(0, 1, 0, 4'b0000, 1, 1, 1, 0,  1, 2'd1, 1, 2'b10);
        vecs[10] = mk(0, 1, 0, 4'b0000, 1, 0, 1, 0,  0, 2'd1, 1, 2'b10);
        vecs[11] = mk(0, 1, 0, 4'b0000, 1, 1, 1, 0,  0, 2'd1, 1, 2'b10);
        vecs[12] = mk(0, 1, 0, 4'b0000, 1, 1, 1, 0,  1, 2'd2, 1, 2'b10);
        // clr without a match, then reload to restart the window.
        vecs[13] = mk(0, 1, 0, 4'b0000, 1, 0, 0, 1,  0, 2'd0, 0, 2'b10);
        vecs[14] = mk(0, 1, 1, 4'b1011, 0, 0, 0, 0,  0, 2'd0, 0, 2'b01);
        // Non-overlap stream 1,0,1,1,0,1,1 -> single match, ends in ARM.
        vecs[15] = mk(0, 1, 0, 4'b0000, 0, 1, 1, 0,  0, 2'd0, 0, 2'b01);
        vecs[16] = mk(0, 1, 0, 4'b0000, 0, 0, 1, 0,  0, 2'd0, 0, 2'b01);
        vecs[17] = mk(0, 1, 0, 4'b0000, 0, 1, 1, 0,  0, 2'd0, 0, 2'b01);
        vecs[18] = mk(0, 1, 0, 4'b0000, 0, 1, 1, 0,  1, 2'd1, 1, 2'b01);
        vecs[19] = mk(0, 1, 0, 4'b0000, 0, 0, 1, 0,  0, 2'd1, 1, 2'b01);
        vecs[20] = mk(0, 1, 0, 4'b0000, 0, 1, 1, 0,  0, 2'd1, 1, 2'b01);
        vecs[21] = mk(0, 1, 0, 4'b0000, 0, 1, 1, 0,  0, 2'd1, 1, 2'b01);
        // Load colliding with a valid bit: window clears, bit dropped.
        vecs[22] = mk(0, 1, 1, 4'b1011, 1, 0, 0, 1,  0, 2'd0, 0, 2'b01);
        vecs[23] = mk(0, 1, 0, 4'b0000, 1, 1, 1, 0,  0, 2'd0, 0, 2'b01);
        vecs[24] = mk(0, 1, 0, 4'b0000, 1, 0, 1, 0,  0, 2'd0, 0, 2'b01);
        vecs[25] = mk(0, 1, 0, 4'b0000, 1, 1, 1, 0,  0, 2'd0, 0, 2'b01);
        vecs[26] = mk(0, 1, 1, 4'b1011, 1, 1, 1, 0,  0, 2'd0, 0, 2'b01);
        vecs[27] = mk(0, 1, 0, 4'b0000, 1, 1, 1, 0,  0, 2'd0, 0, 2'b01);
        vecs[28] = mk(0, 1, 0, 4'b0000, 1, 0, 1, 0,  0, 2'd0, 0, 2'b01);
        vecs[29] = mk(0, 1, 0, 4'b0000, 1, 1, 1, 0,  0, 2'd0, 0, 2'b01);
        vecs[30] = mk(0, 1, 0, 4'b0000, 1, 1, 1, 0,  1, 2'd1, 1, 2'b10);
        // clr in the match cycle: pulse still issued, counter/sticky cleared.
        vecs[31] = mk(0, 1, 0, 4'b0000, 1, 0, 1, 0,  0, 2'd1, 1, 2'b10);
        vecs[32] = mk(0, 1, 0, 4'b0000, 1, 1, 1, 0,  0, 2'd1, 1, 2'b10);
        vecs[33] = mk(0, 1, 0, 4'b0000, 1, 1, 1, 1,  1, 2'd0, 0, 2'b10);
        // en falling with load: IDLE, but pattern becomes 1111.
        vecs[34] = mk(0, 0, 1, 4'b1111, 1, 1, 1, 0,  0, 2'd0, 0, 2'b00);
        vecs[35] = mk(0, 1, 0, 4'b0000, 1, 0, 0, 0,  0, 2'd0, 0, 2'b01);
        // All-ones overlap: five back-to-back matches into a 2-bit counter.
        vecs[36] = mk(0, 1, 0, 4'b0000, 1, 1, 1, 0,  0, 2'd0, 0, 2'b01);
        vecs[37] = mk(0, 1, 0, 4'b0000, 1, 1, 1, 0,  0, 2'd0, 0, 2'b01);
        vecs[38] = mk(0, 1, 0, 4'b0000, 1, 1, 1, 0,  0, 2'd0, 0, 2'b01);
        vecs[39] = mk(0, 1, 0, 4'b0000, 1, 1, 1, 0,  1, 2'd1, 1, 2'b10);
        vecs[40] = mk(0, 1, 0, 4'b0000, 1, 1, 1, 0,  1, 2'd2, 1, 2'b10);
        vecs[41] = mk(0, 1, 0, 4'b0000, 1, 1, 1, 0,  1, 2'd3, 1, 2'b10);
        vecs[42] = mk(0, 1, 0, 4'b0000, 1, 1, 1, 0,  1, EXP_CNT4, 1, 2'b10);
        vecs[43] = mk(0, 1, 0, 4'b0000, 1, 1, 1, 0,  1, EXP_CNT5, 1, 2'b10);
        vecs[44] = mk(0, 1, 0, 4'b0000, 1, 0, 0, 0,  0, EXP_CNT5, 1, 2'b10);

        rst = 1'b1; en = 1'b0; load = 1'b0; pat_in = '0; mode_ovl = 1'b0;
        bit_in = 1'b0; bit_vld = 1'b0; clr = 1'b0;
        #1;

        for (int i = 0; i < 45; i++) begin
            step(vecs[i], i);
        end

        // Mid-stream asynchronous reset: outputs clear without a clock edge.
        en = 1'b1; bit_vld = 1'b1; bit_in = 1'b1;
        rst = 1'b1;
        #2;
        check_two("async_rst_cnt", 100, match_cnt, 2'd0);
        check_two("async_rst_state", 100, state, 2'b00);
        check_bit("async_rst_sticky", 100, sticky, 1'b0);
        check_bit("async_rst_match", 100, match, 1'b0);
        @(posedge clk);
        #1;

        // After reset the pattern is 0000: four zero bits must match.
        step(mk(0, 1, 0, 4'b0000, 1, 0, 0, 0,  0, 2'd0, 0, 2'b01), 101);
        step(mk(0, 1, 0, 4'b0000, 1, 0, 1, 0,  0, 2'd0, 0, 2'b01), 102);
        step(mk(0, 1, 0, 4'b0000, 1, 0, 1, 0,  0, 2'd0, 0, 2'b01), 103);
        step(mk(0, 1, 0, 4'b0000, 1, 0, 1, 0,  0, 2'd0, 0, 2'b01), 104);
        step(mk(0, 1, 0, 4'b0000, 1, 0, 1, 0,  1, 2'd1, 1, 2'b10), 105);
        // Switch to non-overlap mid-stream: next zero matches and re-arms.
        step(mk(0, 1, 0, 4'b0000, 0, 0, 1, 0,  1, 2'd2, 1, 2'b01), 106);
        step(mk(0, 1, 0, 4'b0000, 0, 0, 1, 0,  0, 2'd2, 1, 2'b01), 107);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
